avalon_sdram_arbiter: RTL and testbench

- Two-master Avalon-MM arbiter that shares the single Avalon slave port of the SDRAM controller.
- Arbitration is round-robin. A granted command stays locked through slave waitrequest.
- Read data returns in order. Each returning beat is steered to the master that issued the read, using an in-order tag FIFO.
- Sits between the system interconnect (e.g. CPU port and video/DMA port) and the SDRAM controller.

---
 rtl/avalon_sdram_arbiter_pkg.sv | 25 ++
 rtl/avalon_sdram_arbiter_if.sv | 28 ++
 rtl/arb_tag_fifo.sv | 52 +++++
 rtl/avalon_sdram_arbiter.sv | 132 +++++++++++++
 tb/tb_avalon_sdram_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_sdram_arbiter_pkg.sv
// Shared types and constants for the two-master SDRAM port arbiter.
// Optional build macro: AVS_ARB_FIXED_PRIORITY_EN (master 0 always wins).
package avalon_sdram_arbiter_pkg;

    localparam int AVS_AW_DEF = 24;
    localparam int AVS_DW_DEF = 16;
    localparam int AVS_BW_DEF = 2;
    localparam int MASTER_ID_W = 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Both eligible: the master that did not win last time goes next.
    function automatic logic rr_pick(
        input logic r0,
        input logic r1,
        input logic last
    );
        if (r0 & r1) return ~last;
        return ~r0;
    endfunction

endpackage

// File: rtl/avalon_sdram_arbiter_if.sv
// Avalon-MM command/response bundle shared by both masters and the slave.
// master drives commands, slave answers with waitrequest and read data.
interface avalon_sdram_arbiter_if #(
    parameter int AW = 24,
    parameter int DW = 16,
    parameter int BW = 2
) ();

    logic          read;
    logic          write;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;
    logic [BW-1:0] byteenable;
    logic [DW-1:0] readdata;
    logic          waitrequest;
    logic          readdatavalid;

    modport master (
        output read, write, address, writedata, byteenable,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        input  read, write, address, writedata, byteenable,
        output readdata, waitrequest, readdatavalid
    );

endinterface

// File: rtl/arb_tag_fifo.sv
// In-order 1-bit master tag FIFO for outstanding reads.
// DEPTH must be a power of two so the pointers wrap naturally.
module arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/avalon_sdram_arbiter.sv
// Two-master Avalon-MM arbiter in front of the SDRAM controller slave port.
// Round-robin by default; AVS_ARB_FIXED_PRIORITY_EN makes master 0 win ties.
module avalon_sdram_arbiter
    import avalon_sdram_arbiter_pkg::*;
#(
    parameter int AVS_AW      = AVS_AW_DEF,
    parameter int AVS_DW      = AVS_DW_DEF,
    parameter int AVS_BW      = AVS_BW_DEF,
    parameter int MAX_PENDING = 4
) (
    input  logic clk,
    input  logic reset,
    avalon_sdram_arbiter_if.slave  m0,
    avalon_sdram_arbiter_if.slave  m1,
    avalon_sdram_arbiter_if.master s
);

    arb_state_e state;
    logic       owner;
`ifndef AVS_ARB_FIXED_PRIORITY_EN
    logic       rr_last;
`endif

    logic fifo_full;
    logic fifo_empty;
    logic fifo_head;

    logic req0;
    logic req1;
    logic any_req;
    logic winner;
    logic active;
    logic sel;
    logic sel_wr;
    logic sel_rd;
    logic accept;
    logic push;
    logic pop;

    logic [AVS_AW-1:0] addr_mux;
    logic [AVS_DW-1:0] wdata_mux;
    logic [AVS_BW-1:0] be_mux;

    // Reads stall on a full tag FIFO; writes carry no tag.
    assign req0    = m0.write | (m0.read & ~fifo_full);
    assign req1    = m1.write | (m1.read & ~fifo_full);
    assign any_req = req0 | req1;

`ifdef AVS_ARB_FIXED_PRIORITY_EN
    assign winner = ~req0;
`else
    assign winner = rr_pick(req0, req1, rr_last);
`endif

    assign active = ~reset & ((state == ST_LOCKED) | any_req);
    assign sel    = (state == ST_LOCKED) ? owner : winner;

    assign sel_wr = sel ? m1.write : m0.write;
    assign sel_rd = (sel ? m1.read : m0.read) & ~sel_wr;

    assign addr_mux  = sel ? m1.address    : m0.address;
    assign wdata_mux = sel ? m1.writedata  : m0.writedata;
    assign be_mux    = sel ? m1.byteenable : m0.byteenable;

    assign s.read       = active & sel_rd;
    assign s.write      = active & sel_wr;
    assign s.address    = addr_mux;
    assign s.writedata  = wdata_mux;
    assign s.byteenable = be_mux;

    assign accept = active & ~s.waitrequest;
    assign push   = accept & sel_rd;
    assign pop    = ~reset & s.readdatavalid & ~fifo_empty;

    // Unselected masters stall only when they have something pending.
    assign m0.waitrequest = reset |
        ((active & ~sel) ? s.waitrequest : (m0.read | m0.write));
    assign m1.waitrequest = reset |
        ((active & sel) ? s.waitrequest : (m1.read | m1.write));

    assign m0.readdatavalid = pop & ~fifo_head;
    assign m1.readdatavalid = pop & fifo_head;
    assign m0.readdata      = s.readdata;
    assign m1.readdata      = s.readdata;

    arb_tag_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (sel),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            owner   <= 1'b0;
`ifndef AVS_ARB_FIXED_PRIORITY_EN
            rr_last <= 1'b1;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        if (s.waitrequest) begin
                            state <= ST_LOCKED;
                            owner <= winner;
                        end else begin
`ifndef AVS_ARB_FIXED_PRIORITY_EN
                            rr_last <= winner;
`endif
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!s.waitrequest) begin
                        state   <= ST_IDLE;
`ifndef AVS_ARB_FIXED_PRIORITY_EN
                        rr_last <= owner;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_sdram_arbiter.sv
// Self-checking bench for avalon_sdram_arbiter: queue-based reference
// model checked every cycle plus directed literal expectations.
module tb_avalon_sdram_arbiter;
    import avalon_sdram_arbiter_pkg::*;

    localparam int AW   = 24;
    localparam int DW   = 16;
    localparam int BW   = 2;
    localparam int MAXP = 4;
`ifdef AVS_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    avalon_sdram_arbiter_if #(.AW(AW), .DW(DW), .BW(BW)) m0_if ();
    avalon_sdram_arbiter_if #(.AW(AW), .DW(DW), .BW(BW)) m1_if ();
    avalon_sdram_arbiter_if #(.AW(AW), .DW(DW), .BW(BW)) s_if ();

    avalon_sdram_arbiter #(
        .AVS_AW      (AW),
        .AVS_DW      (DW),
        .AVS_BW      (BW),
        .MAX_PENDING (MAXP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: arbitration state plus a queue of read owners.
    bit mdl_locked = 1'b0;
    bit mdl_owner  = 1'b0;
    bit mdl_rr     = 1'b1;
    bit tags[$];

    bit          x_active, x_g, x_s_read, x_s_write;
    bit          x_wr0, x_wr1, x_rdv0, x_rdv1;
    logic [31:0] x_addr, x_wdata, x_be;

    function automatic bit mr(input bit n);
        return n ? m1_if.read : m0_if.read;
    endfunction

    function automatic bit mw(input bit n);
        return n ? m1_if.write : m0_if.write;
    endfunction

    function automatic void model_eval();
        bit full, e0, e1;
        full = tags.size() >= MAXP;
        e0 = m0_if.write | (m0_if.read & !full);
        e1 = m1_if.write | (m1_if.read & !full);
        x_active = 1'b0;
        x_g = 1'b0;
        if (!reset) begin
            if (mdl_locked) begin
                x_active = 1'b1;
                x_g = mdl_owner;
            end else if (e0 | e1) begin
                x_active = 1'b1;
                if (e0 & e1) x_g = FIXED ? 1'b0 : !mdl_rr;
                else x_g = e1;
            end
        end
        x_s_write = x_active & mw(x_g);
        x_s_read  = x_active & mr(x_g) & !mw(x_g);
        x_addr  = 32'(x_g ? m1_if.address : m0_if.address);
        x_wdata = 32'(x_g ? m1_if.writedata : m0_if.writedata);
        x_be    = 32'(x_g ? m1_if.byteenable : m0_if.byteenable);
        if (reset) begin
            x_wr0 = 1'b1;
            x_wr1 = 1'b1;
        end else begin
            x_wr0 = (x_active && x_g == 1'b0) ? s_if.waitrequest : (mr(0) | mw(0));
            x_wr1 = (x_active && x_g == 1'b1) ? s_if.waitrequest : (mr(1) | mw(1));
        end
        x_rdv0 = !reset && s_if.readdatavalid && tags.size() > 0 && tags[0] == 1'b0;
        x_rdv1 = !reset && s_if.readdatavalid && tags.size() > 0 && tags[0] == 1'b1;
    endfunction

    initial forever begin
        @(posedge clk);
        model_eval();
        if (reset) begin
            mdl_locked = 1'b0;
            mdl_owner = 1'b0;
            mdl_rr = 1'b1;
            tags.delete();
        end else begin
            if (s_if.readdatavalid && tags.size() > 0) void'(tags.pop_front());
            if (x_active && !s_if.waitrequest && x_s_read) tags.push_back(x_g);
            if (mdl_locked) begin
                if (!s_if.waitrequest) begin
                    mdl_rr = mdl_owner;
                    mdl_locked = 1'b0;
                end
            end else if (x_active) begin
                if (s_if.waitrequest) begin
                    mdl_locked = 1'b1;
                    mdl_owner = x_g;
                end else begin
                    mdl_rr = x_g;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        model_eval();
        chk("s_read", 32'(s_if.read), 32'(x_s_read));
        chk("s_write", 32'(s_if.write), 32'(x_s_write));
        chk("m0_wait", 32'(m0_if.waitrequest), 32'(x_wr0));
        chk("m1_wait", 32'(m1_if.waitrequest), 32'(x_wr1));
        chk("m0_rdv", 32'(m0_if.readdatavalid), 32'(x_rdv0));
        chk("m1_rdv", 32'(m1_if.readdatavalid), 32'(x_rdv1));
        chk("m0_rdata", 32'(m0_if.readdata), 32'(s_if.readdata));
        chk("m1_rdata", 32'(m1_if.readdata), 32'(s_if.readdata));
        if (x_active) begin
            chk("s_addr", 32'(s_if.address), x_addr);
            chk("s_wdata", 32'(s_if.writedata), x_wdata);
            chk("s_be", 32'(s_if.byteenable), x_be);
        end
    end

    task automatic idle_in();
        m0_if.read = 0; m0_if.write = 0; m0_if.address = '0;
        m0_if.writedata = '0; m0_if.byteenable = '0;
        m1_if.read = 0; m1_if.write = 0; m1_if.address = '0;
        m1_if.writedata = '0; m1_if.byteenable = '0;
        s_if.waitrequest = 0; s_if.readdatavalid = 0; s_if.readdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_in();
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [31:0] exp_addr [3];
    logic        exp_rdv0 [3];

    initial begin
        idle_in();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_m0_wait", 32'(m0_if.waitrequest), 1);
        chk("rst_m1_wait", 32'(m1_if.waitrequest), 1);
        chk("rst_s_read", 32'(s_if.read), 0);
        chk("rst_m0_rdv", 32'(m0_if.readdatavalid), 0);
        tick();
        tick();
        reset = 1'b0;

        // single master write
        m0_if.write = 1; m0_if.address = 24'h000010;
        m0_if.writedata = 16'hBEEF; m0_if.byteenable = 2'b11;
        @(negedge clk);
        chk("w_s_write", 32'(s_if.write), 1);
        chk("w_s_addr", 32'(s_if.address), 'h10);
        chk("w_s_wdata", 32'(s_if.writedata), 'hBEEF);
        chk("w_m0_wait", 32'(m0_if.waitrequest), 0);
        chk("w_m1_wait", 32'(m1_if.waitrequest), 0);
        tick();
        idle_in();

        // contention
        if (FIXED) begin
            exp_addr = '{'h100, 'h100, 'h100};
            exp_rdv0 = '{1'b1, 1'b1, 1'b1};
        end else begin
            exp_addr = '{'h100, 'h200, 'h100};
            exp_rdv0 = '{1'b1, 1'b0, 1'b1};
        end
        do_reset();
        m0_if.read = 1; m0_if.address = 24'h100;
        m1_if.read = 1; m1_if.address = 24'h200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rr_addr", 32'(s_if.address), exp_addr[i]);
            tick();
        end
        m0_if.read = 0;
        m1_if.read = 0;
        for (int i = 0; i < 3; i++) begin
            s_if.readdatavalid = 1;
            s_if.readdata = 16'(16'hD000 + i);
            @(negedge clk);
            chk("rr_m0_rdv", 32'(m0_if.readdatavalid), 32'(exp_rdv0[i]));
            chk("rr_m1_rdv", 32'(m1_if.readdatavalid), 32'(!exp_rdv0[i]));
            chk("rr_rdata", 32'(m0_if.readdata), 32'(16'hD000 + i));
            tick();
        end
        idle_in();

        // lock through waitrequest
        do_reset();
        m0_if.read = 1; m0_if.address = 24'h300;
        m1_if.write = 1; m1_if.address = 24'h400; m1_if.writedata = 16'h1234;
        s_if.waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lk_s_read", 32'(s_if.read), 1);
            chk("lk_addr", 32'(s_if.address), 'h300);
            chk("lk_m0_wait", 32'(m0_if.waitrequest), 1);
            chk("lk_m1_wait", 32'(m1_if.waitrequest), 1);
            tick();
        end
        s_if.waitrequest = 0;
        @(negedge clk);
        chk("lk_rel_addr", 32'(s_if.address), 'h300);
        chk("lk_rel_m0_wait", 32'(m0_if.waitrequest), 0);
        tick();
        m0_if.read = 0;
        @(negedge clk);
        chk("lk_m1_write", 32'(s_if.write), 1);
        chk("lk_m1_addr", 32'(s_if.address), 'h400);
        chk("lk_m1_wait", 32'(m1_if.waitrequest), 0);
        tick();
        idle_in();

        // tag FIFO full
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m0_if.read = 1;
            m0_if.address = 24'(24'h10 + i);
            @(negedge clk);
            chk("ff_addr", 32'(s_if.address), 32'(24'h10 + i));
            tick();
        end
        m0_if.address = 24'h14;
        m1_if.write = 1; m1_if.address = 24'h500;
        @(negedge clk);
        chk("ff_count", 32'(dut.u_fifo.count), 4);
        chk("ff_m0_wait", 32'(m0_if.waitrequest), 1);
        chk("ff_s_write", 32'(s_if.write), 1);
        chk("ff_w_addr", 32'(s_if.address), 'h500);
        chk("ff_m1_wait", 32'(m1_if.waitrequest), 0);
        tick();
        m1_if.write = 0;
        s_if.readdatavalid = 1; s_if.readdata = 16'hAAAA;
        @(negedge clk);
        chk("ff_pop_m0_wait", 32'(m0_if.waitrequest), 1);
        chk("ff_pop_s_read", 32'(s_if.read), 0);
        chk("ff_pop_m0_rdv", 32'(m0_if.readdatavalid), 1);
        tick();
        s_if.readdatavalid = 0;
        @(negedge clk);
        chk("ff_adm_s_read", 32'(s_if.read), 1);
        chk("ff_adm_addr", 32'(s_if.address), 'h14);
        chk("ff_adm_m0_wait", 32'(m0_if.waitrequest), 0);
        tick();
        idle_in();

        // stray valid, then reset while locked
        do_reset();
        s_if.readdatavalid = 1;
        @(negedge clk);
        chk("st_m0_rdv", 32'(m0_if.readdatavalid), 0);
        chk("st_m1_rdv", 32'(m1_if.readdatavalid), 0);
        tick();
        s_if.readdatavalid = 0;
        m1_if.read = 1; m1_if.address = 24'h600;
        s_if.waitrequest = 1;
        @(negedge clk);
        chk("st_s_read", 32'(s_if.read), 1);
        chk("st_m1_wait", 32'(m1_if.waitrequest), 1);
        tick();
        reset = 1;
        @(negedge clk);
        chk("rl_m1_wait", 32'(m1_if.waitrequest), 1);
        chk("rl_s_read", 32'(s_if.read), 0);
        tick();
        reset = 0;
        m1_if.read = 0;
        s_if.waitrequest = 0;
        s_if.readdatavalid = 1;
        @(negedge clk);
        chk("rl_state", 32'(dut.state), 32'(ST_IDLE));
        chk("rl_count", 32'(dut.u_fifo.count), 0);
        chk("rl_s_read", 32'(s_if.read), 0);
        chk("rl_m1_rdv", 32'(m1_if.readdatavalid), 0);
        tick();
        idle_in();

        // continuous contention with data returning every cycle
        do_reset();
        m0_if.read = 1; m0_if.address = 24'h700;
        m1_if.read = 1; m1_if.address = 24'h800;
        s_if.readdatavalid = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("cc_addr", 32'(s_if.address),
                (FIXED || i % 2 == 0) ? 32'h700 : 32'h800);
            chk("cc_m1_wait", 32'(m1_if.waitrequest),
                (FIXED || i % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        idle_in();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
